// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module : delay_pkg
//  Brief  : Shared sizing rules and pointer wrap helper for the delay blocks.
//  Rev    : 1.0  initial release
// ============================================================================
package delay_pkg;

  // Pointer width; DEPTH below 2 is rejected by the users, this only keeps it >0.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 32'd1 : $clog2(depth);
  endfunction

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non power-of-two depths work.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_elastic_if.sv
`default_nettype none
// ============================================================================
//  Module : delay_elastic_if
//  Brief  : Valid/ready stream bundle used on both ends of delay_elastic.
//  Rev    : 1.0  initial release
// ============================================================================
interface delay_elastic_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/delay_elastic.sv
`default_nettype none
// ============================================================================
//  Module : delay_elastic
//  Brief  : DEPTH-entry order-preserving elastic buffer with registered
//           valid/ready on both sides; minimum latency one cycle.
//  Rev    : 1.0  initial release
// ============================================================================
module delay_elastic
  import delay_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  delay_elastic_if.slave                 sink_if,
  delay_elastic_if.master                source_if,
  output logic [lvl_w(DEPTH)-1:0]        level
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0] C_DEPTH_LVL = LVL_W'(DEPTH);

  if (DEPTH < 2 || WIDTH < 1) begin : g_param_check
    $error("delay_elastic: DEPTH must be >= 2 and WIDTH >= 1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_sink_ready;

  logic             w_push;
  logic             w_pop;
  logic             w_source_valid;
  logic [LVL_W-1:0] w_level_next;
  logic             w_ready_next;

  assign w_source_valid = (r_level != '0);
  assign w_push         = sink_if.valid & r_sink_ready;
  assign w_pop          = w_source_valid & source_if.ready;

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_level_next = r_level - 1'b1;
    end
    // Ready looks only at the updated level, so a pop while full shows up next cycle.
    w_ready_next = (w_level_next < C_DEPTH_LVL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_sink_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= sink_if.data;
        r_wr_ptr        <= PTR_W'(ptr_wrap(32'(r_wr_ptr), DEPTH));
      end
      if (w_pop) begin
        r_rd_ptr <= PTR_W'(ptr_wrap(32'(r_rd_ptr), DEPTH));
      end
      r_level      <= w_level_next;
      r_sink_ready <= w_ready_next;
    end
  end

  assign sink_if.ready    = r_sink_ready;
  assign source_if.data   = r_mem[r_rd_ptr];
  assign source_if.valid  = w_source_valid;
  assign level            = r_level;

endmodule
`default_nettype wire

// File: tb/tb_delay_elastic.sv
`default_nettype none
// ============================================================================
//  Module : tb_delay_elastic
//  Brief  : Directed vector table plus corner sequences and random scoreboard
//           runs for delay_elastic at DEPTH 4, 2 and 5.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_delay_elastic;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  delay_elastic_if #(.WIDTH(8)) snk4 ();
  delay_elastic_if #(.WIDTH(8)) src4 ();
  delay_elastic_if #(.WIDTH(8)) snk2 ();
  delay_elastic_if #(.WIDTH(8)) src2 ();
  delay_elastic_if #(.WIDTH(8)) snk5 ();
  delay_elastic_if #(.WIDTH(8)) src5 ();

  logic [2:0] level4;
  logic [1:0] level2;
  logic [2:0] level5;

  delay_elastic #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sink_if(snk4), .source_if(src4), .level(level4));
  delay_elastic #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sink_if(snk2), .source_if(src2), .level(level2));
  delay_elastic #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .sink_if(snk5), .source_if(src5), .level(level5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       sr;
    logic [2:0] lvl;
    logic       vld;
    logic       chk_src;
    logic [7:0] src;
    logic       rdy;
  } vec_t;

  vec_t vecs [14];
  logic [7:0] q2 [$];
  logic [7:0] q5 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] d, input logic sr);
    snk4.valid = sv;
    snk4.data  = d;
    src4.ready = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic rchk(input string nm, input int depth, input int exp_n, input logic [7:0] exp_front,
                      input int lvl, input logic vld, input logic [7:0] src, input logic rdy);
    chk({nm, "_level"}, 32'(lvl), 32'(exp_n));
    chk({nm, "_bound"}, 32'(lvl <= depth), 32'd1);
    chk({nm, "_valid"}, 32'(vld), 32'(exp_n != 0));
    chk({nm, "_ready"}, 32'(rdy), 32'(exp_n < depth));
    if (exp_n != 0) chk({nm, "_data"}, 32'(src), 32'(exp_front));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    snk4.valid = 0; snk4.data = 0; src4.ready = 0;
    snk2.valid = 0; snk2.data = 0; src2.ready = 0;
    snk5.valid = 0; snk5.data = 0; src5.ready = 0;

    // stream with source_ready=1, then fill to full with backpressure
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 3'd1, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 3'd1, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 3'd1, 1'b1, 1'b1, 8'h33, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 8'hA0, 1'b0, 3'd1, 1'b1, 1'b1, 8'hA0, 1'b1};
    vecs[5]  = '{1'b1, 8'hA1, 1'b0, 3'd2, 1'b1, 1'b1, 8'hA0, 1'b1};
    vecs[6]  = '{1'b1, 8'hA2, 1'b0, 3'd3, 1'b1, 1'b1, 8'hA0, 1'b1};
    vecs[7]  = '{1'b1, 8'hA3, 1'b0, 3'd4, 1'b1, 1'b1, 8'hA0, 1'b0};
    vecs[8]  = '{1'b1, 8'hA4, 1'b0, 3'd4, 1'b1, 1'b1, 8'hA0, 1'b0};
    vecs[9]  = '{1'b1, 8'hA4, 1'b1, 3'd3, 1'b1, 1'b1, 8'hA1, 1'b1};
    vecs[10] = '{1'b1, 8'hA4, 1'b1, 3'd3, 1'b1, 1'b1, 8'hA2, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 8'hA3, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 8'hA4, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1};

    // reset asserted away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready",  32'(snk4.ready), 32'd0);
    chk("rst_valid",  32'(src4.valid), 32'd0);
    chk("rst_level",  32'(level4),     32'd0);
    chk("rst_source", 32'(src4.data),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", 32'(snk4.ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready_post", 32'(snk4.ready), 32'd1);
    chk("rel_level",      32'(level4),     32'd0);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].sv, vecs[i].d, vecs[i].sr);
      chk($sformatf("vec%0d_level", i), 32'(level4),     32'(vecs[i].lvl));
      chk($sformatf("vec%0d_valid", i), 32'(src4.valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_ready", i), 32'(snk4.ready), 32'(vecs[i].rdy));
      if (vecs[i].chk_src) chk($sformatf("vec%0d_source", i), 32'(src4.data), 32'(vecs[i].src));
    end

    // wrap: hold level at 2 and stream 10 words through
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    chk("wrap_fill_level", 32'(level4), 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap%0d_source", i), 32'(src4.data),  32'(i));
      chk($sformatf("wrap%0d_level", i),  32'(level4),     32'd2);
      chk($sformatf("wrap%0d_valid", i),  32'(src4.valid), 32'd1);
      step(1'b1, 8'(i + 2), 1'b1);
    end
    chk("wrap_tail0", 32'(src4.data), 32'd10);
    step(1'b0, 8'd0, 1'b1);
    chk("wrap_tail1", 32'(src4.data), 32'd11);
    chk("wrap_tail1_level", 32'(level4), 32'd1);
    step(1'b0, 8'd0, 1'b1);
    chk("wrap_empty_valid", 32'(src4.valid), 32'd0);

    // reset while holding three words
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    chk("midrst_pre_level", 32'(level4), 32'd3);
    snk4.valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_level",  32'(level4),     32'd0);
    chk("midrst_valid",  32'(src4.valid), 32'd0);
    chk("midrst_ready",  32'(snk4.ready), 32'd0);
    chk("midrst_source", 32'(src4.data),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_back", 32'(snk4.ready), 32'd1);
    step(1'b1, 8'h5A, 1'b1);
    chk("post_rst_source", 32'(src4.data),  32'h5A);
    chk("post_rst_valid",  32'(src4.valid), 32'd1);
    chk("post_rst_level",  32'(level4),     32'd1);
    step(1'b0, 8'd0, 1'b1);
    chk("post_rst_drain", 32'(src4.valid), 32'd0);
    step(1'b0, 8'd0, 1'b1);
    chk("post_rst_nostale", 32'(src4.valid), 32'd0);

    // random traffic on DEPTH=2 and DEPTH=5 against a queue model
    for (int c = 0; c < 2000; c++) begin
      rchk("d2", 2, q2.size(), (q2.size() != 0) ? q2[0] : 8'h00,
           int'(level2), src2.valid, src2.data, snk2.ready);
      rchk("d5", 5, q5.size(), (q5.size() != 0) ? q5[0] : 8'h00,
           int'(level5), src5.valid, src5.data, snk5.ready);
      snk2.valid = 1'($urandom_range(0, 1));
      snk2.data  = 8'($urandom);
      src2.ready = 1'($urandom_range(0, 1));
      snk5.valid = 1'($urandom_range(0, 3) != 0);
      snk5.data  = 8'($urandom);
      src5.ready = 1'($urandom_range(0, 2) == 0);
      if (src2.valid && src2.ready) void'(q2.pop_front());
      if (snk2.valid && snk2.ready) q2.push_back(snk2.data);
      if (src5.valid && src5.ready) void'(q5.pop_front());
      if (snk5.valid && snk5.ready) q5.push_back(snk5.data);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
